// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl
//
// Multi-channel servo PWM generator. Each channel holds a current pulse width
// that moves toward a commanded target by at most STEP ticks per PWM frame.
// The pen servo and any extra actuators therefore never see a sudden jump in
// commanded position. The timebase comes from an external one-clk-wide
// strobe (clk_en), so the frame length is PERIOD strobes rather than PERIOD
// clocks.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   clk_en     in   timebase strobe, one clk wide
//   enable     in   0 forces every output low; counter and ramping keep going
//   cmd_valid  in   width command present
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready
//   cmd_ch     in   target channel index
//   cmd_width  in   requested pulse width in ticks (clamped to MIN_W..MAX_W)
//   cmd_err    out  one-clk pulse after a command addressed a missing channel
//   out        out  PWM outputs, bit i = channel i
//   settled    out  bit i high when channel i has reached its target
//   frame_tick out  one-clk pulse in the cycle after each frame wrap

module servo_ramp_ctrl #(
   parameter int NUM_CH      = 2,
   parameter int CH_BITS     = 1,
   parameter int PERIOD_BITS = 8,
   parameter int PERIOD      = 200,
   parameter int MIN_W       = 10,
   parameter int MAX_W       = 20,
   parameter int STEP        = 1,
   parameter int INIT_W      = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic                   enable,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [CH_BITS-1:0]     cmd_ch,
   input  logic [PERIOD_BITS-1:0] cmd_width,
   output logic                   cmd_err,
   output logic [NUM_CH-1:0]      out,
   output logic [NUM_CH-1:0]      settled,
   output logic                   frame_tick
);

   localparam logic [PERIOD_BITS-1:0] LAST_CNT = PERIOD_BITS'(PERIOD - 1);
   localparam logic [PERIOD_BITS-1:0] MIN_V    = PERIOD_BITS'(MIN_W);
   localparam logic [PERIOD_BITS-1:0] MAX_V    = PERIOD_BITS'(MAX_W);
   localparam logic [PERIOD_BITS-1:0] STEP_V   = PERIOD_BITS'(STEP);
   localparam logic [PERIOD_BITS-1:0] INIT_V   = PERIOD_BITS'(INIT_W);

   logic [PERIOD_BITS-1:0] cnt;
   logic [PERIOD_BITS-1:0] cur_w [NUM_CH];
   logic [PERIOD_BITS-1:0] tgt_w [NUM_CH];
   logic [PERIOD_BITS-1:0] cur_next [NUM_CH];
   logic [PERIOD_BITS-1:0] width_clamped;
   logic                   wrap;
   logic                   accept;
   logic                   ch_in_range;

   // A frame ends on the strobe that would take the counter past PERIOD-1.
   // Widths may only change on this event so a pulse is never cut short or
   // stretched in the middle of a frame.
   assign wrap        = clk_en && (cnt == LAST_CNT);
   assign accept      = cmd_valid && cmd_ready;
   assign ch_in_range = (32'(cmd_ch) < 32'(NUM_CH));

   // Requested widths outside the servo's mechanical range are pulled onto
   // the nearest legal limit instead of being rejected.
   always_comb begin
      width_clamped = cmd_width;
      if (cmd_width < MIN_V) begin
         width_clamped = MIN_V;
      end else if (cmd_width > MAX_V) begin
         width_clamped = MAX_V;
      end
   end

   // One ramp step per channel toward the target. The difference is taken
   // in the direction of travel, so the step is limited to what remains and
   // the width can never overshoot.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cur_next[i] = cur_w[i];
         if (cur_w[i] < tgt_w[i]) begin
            if ((tgt_w[i] - cur_w[i]) < STEP_V) begin
               cur_next[i] = tgt_w[i];
            end else begin
               cur_next[i] = cur_w[i] + STEP_V;
            end
         end else if (cur_w[i] > tgt_w[i]) begin
            if ((cur_w[i] - tgt_w[i]) < STEP_V) begin
               cur_next[i] = tgt_w[i];
            end else begin
               cur_next[i] = cur_w[i] - STEP_V;
            end
         end
      end
   end

   // Frame counter, frame strobe, and command handshake. cmd_ready comes up
   // on the first clock after reset is released and then stays high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         frame_tick <= 1'b0;
         cmd_ready  <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         cmd_ready  <= 1'b1;
         frame_tick <= wrap;
         cmd_err    <= accept && !ch_in_range;
         if (clk_en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
         end
      end
   end

   // Per-channel width state. The ramp step at a wrap reads the target as it
   // stood before this clock, so a command landing on the wrap clock only
   // steers the following frame. Outputs compare against the counter value
   // from the previous clock, which gives a clean one-clk registered delay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out     <= '0;
         settled <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            cur_w[i] <= INIT_V;
            tgt_w[i] <= INIT_V;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            out[i]     <= enable && (cnt < cur_w[i]);
            settled[i] <= (cur_w[i] == tgt_w[i]);
            if (wrap) begin
               cur_w[i] <= cur_next[i];
            end
            if (accept && ch_in_range && (32'(cmd_ch) == i)) begin
               tgt_w[i] <= width_clamped;
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl
//
// Directed bench for servo_ramp_ctrl with a short 40-tick frame and a strobe
// on every other clock. Pulse widths are measured by counting high clocks
// over one whole frame window and halving the count.

module tb_servo_ramp_ctrl;

   localparam int NUM_CH      = 2;
   localparam int CH_BITS     = 2;
   localparam int PERIOD_BITS = 8;
   localparam int PERIOD      = 40;
   localparam int FRAME_CLKS  = 2 * PERIOD;

   logic                   clk;
   logic                   reset;
   logic                   clk_en;
   logic                   enable;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [CH_BITS-1:0]     cmd_ch;
   logic [PERIOD_BITS-1:0] cmd_width;
   logic                   cmd_err;
   logic [NUM_CH-1:0]      out;
   logic [NUM_CH-1:0]      settled;
   logic                   frame_tick;

   int checks = 0;
   int errors = 0;

   servo_ramp_ctrl #(
      .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .PERIOD_BITS(PERIOD_BITS),
      .PERIOD(PERIOD), .MIN_W(10), .MAX_W(20), .STEP(1), .INIT_W(10)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
      .cmd_width(cmd_width), .cmd_err(cmd_err), .out(out),
      .settled(settled), .frame_tick(frame_tick)
   );

   // 10 ns system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Timebase strobe: high for one clock out of every two.
   initial begin
      clk_en = 1'b0;
      forever begin
         @(posedge clk);
         #1 clk_en = ~clk_en;
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Present one command for a single clock, then drop valid.
   task automatic applyStimulus(input logic [CH_BITS-1:0] ch,
                                input logic [PERIOD_BITS-1:0] width);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ch    = ch;
      cmd_width = width;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Wait for a frame_tick (bounded), then count high clocks for a whole
   // frame. Ends on the negedge where the next frame_tick is visible, so
   // back-to-back calls measure consecutive frames.
   task automatic measureFrame(input string tag, input int exp0, input int exp1);
      int budget = 0;
      int high0  = 0;
      int high1  = 0;
      while (!frame_tick && budget < 3 * FRAME_CLKS) begin
         @(negedge clk);
         budget++;
      end
      if (!frame_tick) begin
         checkOutput({tag, "_frame_timeout"}, 0, 1);
      end else begin
         for (int k = 0; k < FRAME_CLKS; k++) begin
            @(negedge clk);
            high0 += int'(out[0]);
            high1 += int'(out[1]);
         end
         checkOutput({tag, "_ch0"}, high0 / 2, exp0);
         checkOutput({tag, "_ch1"}, high1 / 2, exp1);
      end
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b1;
      cmd_valid = 1'b0;
      cmd_ch    = '0;
      cmd_width = '0;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_out", 32'(out), 0);
      checkOutput("rst_settled", 32'(settled), 3);
      checkOutput("rst_ready", 32'(cmd_ready), 0);
      checkOutput("rst_err", 32'(cmd_err), 0);
      checkOutput("rst_tick", 32'(frame_tick), 0);
      reset = 1'b0;
      @(posedge clk);
      #1 checkOutput("ready_after_rst", 32'(cmd_ready), 1);

      // Idle frames at the initial width.
      measureFrame("idle_a", 10, 10);
      measureFrame("idle_b", 10, 10);
      checkOutput("idle_settled", 32'(settled), 3);

      // Ramp channel 0 up to 15, one tick per frame.
      applyStimulus(2'd0, 8'd15);
      repeat (2) @(posedge clk);
      #1 checkOutput("ramp0_settled_drop", 32'(settled), 2);
      for (int w = 11; w <= 15; w++) begin
         measureFrame("ramp0_up", w, 10);
      end
      checkOutput("ramp0_settled", 32'(settled), 3);

      // Over-range request on channel 1 clamps to 20.
      applyStimulus(2'd1, 8'd30);
      for (int w = 11; w <= 20; w++) begin
         measureFrame("ramp1_up", 15, w);
      end
      measureFrame("ramp1_hold", 15, 20);
      checkOutput("ramp1_settled_hi", 32'(settled), 3);

      // Under-range request on channel 1 clamps to 10.
      applyStimulus(2'd1, 8'd2);
      for (int w = 19; w >= 10; w--) begin
         measureFrame("ramp1_down", 15, w);
      end
      measureFrame("ramp1_floor", 15, 10);

      // Command to a channel that does not exist.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ch    = 2'd3;
      cmd_width = 8'd18;
      @(posedge clk);
      #1 checkOutput("bad_ch_err", 32'(cmd_err), 1);
      cmd_valid = 1'b0;
      @(posedge clk);
      #1 checkOutput("bad_ch_err_clear", 32'(cmd_err), 0);
      repeat (2) @(posedge clk);
      #1 checkOutput("bad_ch_settled", 32'(settled), 3);
      measureFrame("bad_ch_frame", 15, 10);

      // A good command does not raise cmd_err.
      applyStimulus(2'd1, 8'd12);
      checkOutput("good_ch_err", 32'(cmd_err), 0);

      // Disable outputs; ramping keeps going underneath.
      enable = 1'b0;
      measureFrame("disabled", 0, 0);
      enable = 1'b1;
      measureFrame("reenabled", 15, 12);

      // Command landing exactly on the wrap clock. We sit on the negedge
      // right after a wrap, so the next wrap edge is FRAME_CLKS edges away.
      for (int k = 0; k < FRAME_CLKS - 1; k++) begin
         @(negedge clk);
      end
      cmd_valid = 1'b1;
      cmd_ch    = 2'd0;
      cmd_width = 8'd20;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("wrap_cmd_tick", 32'(frame_tick), 1);
      measureFrame("wrap_old_tgt", 15, 12);
      measureFrame("wrap_new_tgt", 16, 12);

      // Reset in the middle of a high pulse while channel 0 is still ramping.
      repeat (5) @(negedge clk);
      checkOutput("pre_rst_pulse", 32'(out[0]), 1);
      reset = 1'b1;
      #1 checkOutput("mid_rst_out", 32'(out), 0);
      checkOutput("mid_rst_settled", 32'(settled), 3);
      @(negedge clk);
      reset = 1'b0;
      measureFrame("post_rst", 10, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case something above never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got 1 expected 0");
      $fatal(1, "[TB] timeout");
   end

endmodule
